// File: rtl/div_iter_if.sv
// Request/result bundle between the execute-stage control unit and the
// iterative divider. The control unit is the master; the divider is the slave.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;

  modport master (output start, sign, a, b, input q, r, busy, done);
  modport slave  (input start, sign, a, b, output q, r, busy, done);
endinterface

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Operands are reduced to magnitudes on start. One trial subtraction is done
// per cycle for WIDTH cycles. Signs are then applied in a fix-up cycle. q/r
// are registered there and held until the next accepted request.
module div_iter #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvsr;
  logic [WIDTH-1:0] q_reg, r_reg;
  logic             a_sign, b_sign, sgn, b_zero;
  logic             busy, done;
  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial;

  // A request is only taken while no divide is in flight.
  assign accept    = bus.start && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt == CW'(WIDTH - 1));

  // The most-negative value maps to itself. Read unsigned, that is 2^(WIDTH-1).
  assign a_mag = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  // The partial remainder stays below the divisor, so bit WIDTH of trial is
  // exactly the borrow.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks. Every flop then samples
    // the values from before the edge, whatever order the blocks run in.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default comes first, so every path assigns state_nx and no
    // latch is inferred.
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_iter) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs, decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, FIX: busy = 1'b1;
      DONE:     done = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: load operands, iterate, then apply signs into the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      sgn    <= 1'b0;
      b_zero <= 1'b0;
      q_reg  <= '0;
      r_reg  <= '0;
    end else if (accept) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= a_mag;
      dvsr   <= b_mag;
      a_sign <= bus.a[WIDTH-1];
      b_sign <= bus.b[WIDTH-1];
      sgn    <= bus.sign;
      b_zero <= (bus.b == '0);
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end else if (state == FIX) begin
      // With a zero divisor every trial succeeds: quo becomes all ones and rem
      // becomes |a|. The sign fix-up on rem gives back a. The quotient is
      // forced so that it stays all ones whatever the operand signs are.
      if (b_zero)                   q_reg <= '1;
      else if (sgn && (a_sign ^ b_sign)) q_reg <= -quo;
      else                          q_reg <= quo;
      // Truncating division: the remainder takes the sign of the dividend.
      r_reg <= (sgn && a_sign) ? -rem : rem;
    end
  end

  assign bus.q    = q_reg;
  assign bus.r    = r_reg;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule
